// File: rtl/autoref_pkg.sv
// autoref_pkg: shared width, pending limit and FSM state type for the auto-refresh path.
package autoref_pkg;
   localparam int AREF_CNT_W = 28;
   localparam int AREF_MAX_PENDING = 8;
   typedef enum logic [1:0] {IDLE, REQ, TRFC} state_t;
endpackage

// File: rtl/autoref_scheduler_if.sv
// autoref_scheduler_if: config inputs and arbiter handshake of the auto-refresh scheduler.
// ref_urgent exists only when AREF_URGENT_EN is defined.
interface autoref_scheduler_if #(
   parameter int CNT_W = autoref_pkg::AREF_CNT_W,
   parameter int PEND_W = 4
);
   logic aref_en;
   logic [CNT_W-1:0] aref_interval;
   logic [CNT_W-1:0] trfc;
   logic ref_grant;
   logic ref_req;
   logic ref_busy;
   logic ref_issued;
   logic [PEND_W-1:0] pending_cnt;
   logic ref_overflow;
`ifdef AREF_URGENT_EN
   logic ref_urgent;
`endif
   modport master (
      input aref_en, aref_interval, trfc, ref_grant,
      output ref_req, ref_busy, ref_issued, pending_cnt, ref_overflow
`ifdef AREF_URGENT_EN
      , output ref_urgent
`endif
   );
   modport slave (
      output aref_en, aref_interval, trfc, ref_grant,
      input ref_req, ref_busy, ref_issued, pending_cnt, ref_overflow
`ifdef AREF_URGENT_EN
      , input ref_urgent
`endif
   );
endinterface

// File: rtl/autoref_interval_timer.sv
// autoref_interval_timer: free-running interval counter producing one-cycle refresh ticks.
module autoref_interval_timer #(
   parameter int CNT_W = autoref_pkg::AREF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             aref_en,
   input  logic [CNT_W-1:0] aref_interval,
   output logic             tick
);
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lim;
   // >= rather than == so a shrunk interval ticks at once instead of wrapping
   assign lim = (aref_interval == '0) ? '0 : aref_interval - CNT_W'(1);
   assign tick = aref_en && (cnt >= lim);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (!aref_en || tick) ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/autoref_scheduler.sv
// autoref_scheduler: counts postponed refreshes, requests REF slots and blocks the arbiter for tRFC.
// Define AREF_URGENT_EN to add the ref_urgent output.
module autoref_scheduler import autoref_pkg::*; #(
   parameter int CNT_W = AREF_CNT_W,
   parameter int MAX_PENDING = AREF_MAX_PENDING,
   parameter int PEND_W = 4,
   parameter int URGENT_THRESH = 6
) (
   input logic clk,
   input logic rst,
   autoref_scheduler_if.master bus
);
   localparam logic [PEND_W-1:0] PMAX = PEND_W'(MAX_PENDING);
   if (PEND_W < $clog2(MAX_PENDING + 1) || URGENT_THRESH > MAX_PENDING) begin : g_bad_params
      $error("autoref_scheduler: inconsistent pending parameters");
   end
   state_t state, state_nxt;
   logic tick, grant_acc, issued, ovf, ovf_nxt;
   logic [PEND_W-1:0] pend, pend_nxt;
   logic [CNT_W-1:0] rfc_cnt, rfc_nxt;
   autoref_interval_timer #(.CNT_W(CNT_W)) u_timer (
      .clk(clk),
      .rst(rst),
      .aref_en(bus.aref_en),
      .aref_interval(bus.aref_interval),
      .tick(tick)
   );
   assign grant_acc = (state == REQ) && bus.ref_grant;
   // a tick and a grant together cancel; a tick at the limit is lost and flagged
   always_comb begin
      pend_nxt = pend;
      ovf_nxt = ovf;
      if (!bus.aref_en) pend_nxt = '0;
      else if (tick && !grant_acc) begin
         if (pend == PMAX) ovf_nxt = 1'b1;
         else pend_nxt = pend + 1'b1;
      end else if (grant_acc && !tick) pend_nxt = pend - 1'b1;
   end
   always_comb begin
      state_nxt = state;
      rfc_nxt = rfc_cnt;
      case (state)
         IDLE: if (bus.aref_en && pend != '0) state_nxt = REQ;
         REQ:
            if (bus.ref_grant) begin
               state_nxt = TRFC;
               rfc_nxt = (bus.trfc == '0) ? CNT_W'(1) : bus.trfc;
            end else if (!bus.aref_en) state_nxt = IDLE;
         TRFC:
            if (rfc_cnt <= CNT_W'(1)) state_nxt = (bus.aref_en && pend_nxt != '0) ? REQ : IDLE;
            else rfc_nxt = rfc_cnt - CNT_W'(1);
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         rfc_cnt <= '0;
         pend <= '0;
         ovf <= 1'b0;
         issued <= 1'b0;
      end else begin
         state <= state_nxt;
         rfc_cnt <= rfc_nxt;
         pend <= pend_nxt;
         ovf <= ovf_nxt;
         issued <= grant_acc;
      end
   assign bus.ref_req = (state == REQ);
   assign bus.ref_busy = (state == TRFC);
   assign bus.ref_issued = issued;
   assign bus.pending_cnt = pend;
   assign bus.ref_overflow = ovf;
`ifdef AREF_URGENT_EN
   logic urgent;
   always_ff @(posedge clk or posedge rst)
      if (rst) urgent <= 1'b0;
      else urgent <= (pend_nxt >= PEND_W'(URGENT_THRESH));
   assign bus.ref_urgent = urgent;
`endif
endmodule

// File: tb/tb_autoref_scheduler.sv
// tb_autoref_scheduler: directed vector table plus multi-cycle sequences for autoref_scheduler.
module tb_autoref_scheduler;
   localparam int CW = 28;
   localparam int PW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errors = 0;
   int checks = 0;
   autoref_scheduler_if #(.CNT_W(CW), .PEND_W(PW)) bus ();
   autoref_scheduler #(.CNT_W(CW), .MAX_PENDING(8), .PEND_W(PW), .URGENT_THRESH(6)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic en;
      logic gnt;
      logic req;
      logic busy;
      logic iss;
      int   pend;
   } vec_t;
   vec_t tbl[16];
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.aref_en = 1'b0;
      bus.ref_grant = 1'b0;
      step();
      rst = 1'b0;
   endtask
   task automatic wait_req(input string nm);
      int n = 0;
      while (!bus.ref_req && n < 40) begin
         step();
         n++;
      end
      chk(nm, int'(bus.ref_req), 1);
   endtask
   task automatic chk_zero(input string nm);
      chk({nm, "_req"}, int'(bus.ref_req), 0);
      chk({nm, "_busy"}, int'(bus.ref_busy), 0);
      chk({nm, "_iss"}, int'(bus.ref_issued), 0);
      chk({nm, "_pend"}, int'(bus.pending_cnt), 0);
      chk({nm, "_ovf"}, int'(bus.ref_overflow), 0);
`ifdef AREF_URGENT_EN
      chk({nm, "_urg"}, int'(bus.ref_urgent), 0);
`endif
   endtask
   initial begin
      int iss_t[$];
      int runs[$];
      int run, age, both, nb;
      bus.aref_en = 1'b0;
      bus.ref_grant = 1'b0;
      bus.aref_interval = '0;
      bus.trfc = '0;
      step();
      step();
      chk_zero("reset");
      // interval=3, trfc=2: ticks at edges 3,6,9,12 interleaved with grants
      tbl[0]  = '{1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 0, 0, 0, 0, 1};
      tbl[3]  = '{1, 0, 1, 0, 0, 1};
      tbl[4]  = '{1, 1, 0, 1, 1, 0};
      tbl[5]  = '{1, 0, 0, 1, 0, 1};
      tbl[6]  = '{1, 0, 1, 0, 0, 1};
      tbl[7]  = '{1, 1, 0, 1, 1, 0};
      tbl[8]  = '{1, 1, 0, 1, 0, 1};
      tbl[9]  = '{1, 0, 1, 0, 0, 1};
      tbl[10] = '{1, 0, 1, 0, 0, 1};
      tbl[11] = '{1, 1, 0, 1, 1, 1};
      tbl[12] = '{1, 0, 0, 1, 0, 1};
      tbl[13] = '{1, 0, 1, 0, 0, 1};
      tbl[14] = '{0, 0, 0, 0, 0, 0};
      tbl[15] = '{0, 0, 0, 0, 0, 0};
      do_reset();
      bus.aref_interval = 3;
      bus.trfc = 2;
      for (int i = 0; i < 16; i++) begin
         bus.aref_en = tbl[i].en;
         bus.ref_grant = tbl[i].gnt;
         step();
         chk($sformatf("vec%0d_req", i), int'(bus.ref_req), int'(tbl[i].req));
         chk($sformatf("vec%0d_busy", i), int'(bus.ref_busy), int'(tbl[i].busy));
         chk($sformatf("vec%0d_iss", i), int'(bus.ref_issued), int'(tbl[i].iss));
         chk($sformatf("vec%0d_pend", i), int'(bus.pending_cnt), tbl[i].pend);
         chk($sformatf("vec%0d_ovf", i), int'(bus.ref_overflow), 0);
      end
      // steady refresh: interval 100, trfc 20, grant two cycles into each request
      do_reset();
      bus.aref_interval = 100;
      bus.trfc = 20;
      bus.aref_en = 1'b1;
      run = 0;
      age = 0;
      both = 0;
      for (int c = 1; c <= 420; c++) begin
         step();
         if (bus.ref_req && bus.ref_busy) both++;
         if (bus.ref_issued) iss_t.push_back(c);
         if (bus.ref_busy) run++;
         else if (run != 0) begin
            runs.push_back(run);
            run = 0;
         end
         age = bus.ref_req ? age + 1 : 0;
         bus.ref_grant = (age == 3);
      end
      chk("steady_iss_count", iss_t.size(), 4);
      if (iss_t.size() == 4) begin
         chk("steady_first_iss", iss_t[0], 104);
         for (int i = 1; i < 4; i++) chk($sformatf("steady_gap%0d", i), iss_t[i] - iss_t[i-1], 100);
      end
      chk("steady_runs", runs.size(), 3);
      foreach (runs[i]) chk($sformatf("steady_busy%0d", i), runs[i], 20);
      chk("steady_req_and_busy", both, 0);
      chk("steady_pend", int'(bus.pending_cnt), 0);
      // saturation and sticky overflow
      do_reset();
      bus.aref_interval = 10;
      bus.trfc = 4;
      bus.aref_en = 1'b1;
      repeat (85) step();
      chk("sat_pend85", int'(bus.pending_cnt), 8);
      chk("sat_ovf85", int'(bus.ref_overflow), 0);
      repeat (35) step();
      chk("sat_pend120", int'(bus.pending_cnt), 8);
      chk("sat_ovf120", int'(bus.ref_overflow), 1);
      for (int c = 0; c < 40; c++) begin
         bus.ref_grant = bus.ref_req;
         step();
      end
      bus.ref_grant = 1'b0;
      chk("sat_pend_drain", int'(bus.pending_cnt), 4);
      chk("sat_ovf_sticky", int'(bus.ref_overflow), 1);
      bus.aref_en = 1'b0;
      step();
      chk("sat_dis_pend", int'(bus.pending_cnt), 0);
      chk("sat_dis_ovf", int'(bus.ref_overflow), 1);
      // enable dropped in REQ
      do_reset();
      bus.aref_interval = 5;
      bus.trfc = 20;
      bus.aref_en = 1'b1;
      wait_req("drop_req_wait");
      bus.aref_en = 1'b0;
      step();
      chk("drop_req_req", int'(bus.ref_req), 0);
      chk("drop_req_pend", int'(bus.pending_cnt), 0);
      chk("drop_req_iss", int'(bus.ref_issued), 0);
      // enable dropped in TRFC does not shorten the window
      do_reset();
      bus.aref_en = 1'b1;
      wait_req("drop_trfc_wait");
      bus.ref_grant = 1'b1;
      step();
      bus.ref_grant = 1'b0;
      bus.aref_en = 1'b0;
      chk("drop_trfc_iss", int'(bus.ref_issued), 1);
      nb = int'(bus.ref_busy);
      for (int c = 0; c < 30; c++) begin
         step();
         if (bus.ref_busy) nb++;
      end
      chk("drop_trfc_busy_len", nb, 20);
      chk("drop_trfc_req", int'(bus.ref_req), 0);
      // interval shrink mid-count
      do_reset();
      bus.aref_interval = 100;
      bus.aref_en = 1'b1;
      repeat (50) step();
      chk("shrink_pend50", int'(bus.pending_cnt), 0);
      bus.aref_interval = 30;
      step();
      chk("shrink_pend51", int'(bus.pending_cnt), 1);
      repeat (29) step();
      chk("shrink_pend80", int'(bus.pending_cnt), 1);
      step();
      chk("shrink_pend81", int'(bus.pending_cnt), 2);
      // trfc=0 gives a single busy cycle
      do_reset();
      bus.aref_interval = 4;
      bus.trfc = 0;
      bus.aref_en = 1'b1;
      wait_req("trfc0_wait");
      bus.ref_grant = 1'b1;
      step();
      bus.ref_grant = 1'b0;
      chk("trfc0_busy1", int'(bus.ref_busy), 1);
      chk("trfc0_iss", int'(bus.ref_issued), 1);
      step();
      chk("trfc0_busy2", int'(bus.ref_busy), 0);
      // asynchronous reset in the middle of tRFC
      do_reset();
      bus.trfc = 20;
      bus.aref_en = 1'b1;
      wait_req("arst_wait");
      bus.ref_grant = 1'b1;
      step();
      bus.ref_grant = 1'b0;
      step();
      chk("arst_busy_before", int'(bus.ref_busy), 1);
      #2 rst = 1'b1;
      #1 chk_zero("arst");
      step();
      rst = 1'b0;
`ifdef AREF_URGENT_EN
      do_reset();
      bus.aref_interval = 10;
      bus.trfc = 3;
      bus.aref_en = 1'b1;
      repeat (59) step();
      chk("urg_pend5", int'(bus.pending_cnt), 5);
      chk("urg_low", int'(bus.ref_urgent), 0);
      step();
      chk("urg_pend6", int'(bus.pending_cnt), 6);
      chk("urg_high", int'(bus.ref_urgent), 1);
      bus.ref_grant = 1'b1;
      step();
      bus.ref_grant = 1'b0;
      chk("urg_pend_back5", int'(bus.pending_cnt), 5);
      chk("urg_drop", int'(bus.ref_urgent), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
